// File: rtl/mem_unit.sv
// mem_unit: CPU-side 256x8 RAM on a shared tristate bus, with a boot loader and one MMIO FIFO output port
//   clk, reset            system clock, synchronous active-high reset
//   mem_clk               one-cycle CPU memory strobe qualifying accesses
//   addr_bus, c_mrd/c_mwr CPU address, read and write requests (write wins)
//   bus                   shared data bus, driven only while returning read data
//   cpu_hold              stalls the CPU while a program is being loaded
//   ld_valid/ld_ready     load beat handshake, ld_data byte, ld_last ends the load
//   out_valid/out_ready   output FIFO handshake, out_data is the FIFO head
module mem_unit #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int IO_ADDR    = 'hFF,
   parameter int FIFO_DEPTH = 4,
   parameter bit LOAD_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_clk,
   input  logic [ADDR_W-1:0] addr_bus,
   input  logic              c_mrd,
   input  logic              c_mwr,
   inout  wire  [DATA_W-1:0] bus,
   output logic              cpu_hold,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] L_IO   = ADDR_W'(IO_ADDR);
   localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(IO_ADDR - 1);
   typedef enum logic {S_LOAD, S_RUN} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_ld_ptr;
   logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];
   logic [DATA_W-1:0] r_fifo [0:FIFO_DEPTH-1];
   logic [PW-1:0]     r_wp, r_rp;
   logic [PW:0]       r_cnt;
   logic              r_ovf, r_rd_drive;
   logic [DATA_W-1:0] r_rd_data;
   logic w_beat, w_acc, w_wr, w_rd, w_io, w_push, w_pop, w_full, w_push_ok;
   always_ff @(posedge clk)
      if (reset) r_state <= LOAD_EN ? S_LOAD : S_RUN;
      else       r_state <= w_next;
   // The loader stops one short of the MMIO address so RAM behind it is never written.
   always_comb begin
      w_next   = r_state;
      cpu_hold = r_state == S_LOAD;
      ld_ready = r_state == S_LOAD;
      if (r_state == S_LOAD && ld_valid && (ld_last || r_ld_ptr == L_LAST)) w_next = S_RUN;
   end
   assign w_beat    = ld_ready & ld_valid;
   assign w_acc     = (r_state == S_RUN) & mem_clk;
   assign w_wr      = w_acc & c_mwr;
   assign w_rd      = w_acc & c_mrd & ~c_mwr;
   assign w_io      = addr_bus == L_IO;
   assign w_push    = w_wr & w_io;
   assign w_pop     = out_valid & out_ready;
   assign w_full    = r_cnt == (PW+1)'(FIFO_DEPTH);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok = w_push & (~w_full | w_pop);
   always_ff @(posedge clk)
      if (reset)       r_ld_ptr <= '0;
      else if (w_beat) r_ld_ptr <= r_ld_ptr + 1'b1;
   always_ff @(posedge clk)
      if (w_beat)             r_mem[r_ld_ptr] <= ld_data;
      else if (w_wr && !w_io) r_mem[addr_bus] <= bus;
   always_ff @(posedge clk)
      if (reset) begin
         r_rd_drive <= 1'b0;
         r_rd_data  <= '0;
      end else if (w_rd) begin
         r_rd_data  <= w_io ? {{(DATA_W-2){1'b0}}, r_ovf, w_full} : r_mem[addr_bus];
         r_rd_drive <= 1'b1;
      end else if (!c_mrd) r_rd_drive <= 1'b0;
   always_ff @(posedge clk)
      if (reset)                         r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_rd && w_io)             r_ovf <= 1'b0;
   always_ff @(posedge clk)
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wp] <= bus;
            r_wp         <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop};
      end
   assign out_valid = r_cnt != '0;
   assign out_data  = r_fifo[r_rp];
   assign bus = (r_rd_drive && c_mrd && !c_mwr) ? r_rd_data : 'z;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed and randomized checks of mem_unit against a queue/array reference model
module tb_mem_unit;
   logic       clk = 1'b0;
   logic       reset = 1'b1, mem_clk = 1'b0, c_mrd = 1'b0, c_mwr = 1'b0;
   logic       ld_valid = 1'b0, ld_last = 1'b0, out_ready = 1'b0, tb_en = 1'b0;
   logic [7:0] addr_bus = '0, ld_data = '0, tb_val = '0, got;
   wire  [7:0] bus, out_data;
   wire        cpu_hold, ld_ready, out_valid;
   int         checks = 0, errors = 0;
   bit         m_load, m_ovf;
   int         m_ptr;
   logic [7:0] m_mem [256];
   bit         m_known [256];
   logic [7:0] m_q [$];
   logic [7:0] m_rd;
   assign bus = tb_en ? tb_val : 'z;
   always #5 clk = ~clk;
   mem_unit dut (
      .clk(clk), .reset(reset), .mem_clk(mem_clk), .addr_bus(addr_bus),
      .c_mrd(c_mrd), .c_mwr(c_mwr), .bus(bus), .cpu_hold(cpu_hold),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      bit pop, full, push;
      if (reset) begin
         m_load = 1'b1;
         m_ptr  = 0;
         m_ovf  = 1'b0;
         m_q.delete();
      end else begin
         full = m_q.size() == 4;
         pop  = m_q.size() > 0 && out_ready;
         push = 1'b0;
         if (m_load) begin
            if (ld_valid) begin
               m_mem[m_ptr]   = ld_data;
               m_known[m_ptr] = 1'b1;
               if (ld_last || m_ptr == 254) m_load = 1'b0;
               m_ptr++;
            end
         end else if (mem_clk && c_mwr) begin
            if (addr_bus != 8'hFF) begin
               m_mem[addr_bus]   = tb_val;
               m_known[addr_bus] = 1'b1;
            end else push = 1'b1;
         end else if (mem_clk && c_mrd) begin
            m_rd = addr_bus == 8'hFF ? {6'b0, m_ovf, full} : m_mem[addr_bus];
            if (addr_bus == 8'hFF) m_ovf = 1'b0;
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (!full || pop) m_q.push_back(tb_val);
            else m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("cpu_hold", cpu_hold, m_load);
      chk("ld_ready", ld_ready, m_load);
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
   endtask
   task automatic probe_z(input string tag);
      tb_en  = 1'b1;
      tb_val = 8'h00;
      #1;
      chk(tag, bus, 8'h00);
      tb_en = 1'b0;
   endtask
   task automatic do_read(input logic [7:0] a, input string tag, output logic [7:0] v);
      addr_bus = a;
      c_mrd    = 1'b1;
      mem_clk  = 1'b1;
      tick();
      mem_clk = 1'b0;
      #1;
      v = bus;
      if (!m_load) chk(tag, v, m_rd);
      c_mrd = 1'b0;
      probe_z({tag, "_z"});
      tick();
   endtask
   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit rd_too);
      addr_bus = a;
      tb_val   = d;
      tb_en    = 1'b1;
      c_mwr    = 1'b1;
      c_mrd    = rd_too;
      mem_clk  = 1'b1;
      tick();
      {c_mwr, c_mrd, mem_clk, tb_en} = '0;
   endtask
   task automatic beat(input logic [7:0] d, input bit last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask
   initial begin
      logic [7:0] a;
      reset = 1'b1;
      tick();
      tick();
      chk("rst_out_data", out_data, 8'h00);
      probe_z("rst_bus_z");
      reset = 1'b0;
      beat(8'hA0, 1'b0);
      beat(8'hA1, 1'b0);
      beat(8'hA2, 1'b1);
      tick();
      do_read(8'h02, "rd_02", got);
      chk("rd_02_lit", got, 8'hA2);
      do_read(8'h00, "rd_00", got);
      do_read(8'h01, "rd_01", got);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) do_write(8'hFF, 8'h11 + 8'(i), 1'b0);
      do_read(8'hFF, "stat1", got);
      chk("stat1_lit", got, 8'h03);
      do_read(8'hFF, "stat2", got);
      chk("stat2_lit", got, 8'h01);
      out_ready = 1'b1;
      do_write(8'hFF, 8'h16, 1'b0);
      out_ready = 1'b0;
      do_read(8'hFF, "stat3", got);
      chk("stat3_lit", got, 8'h01);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      beat(8'hB0, 1'b0);
      beat(8'hB1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      beat(8'hC0, 1'b1);
      tick();
      do_read(8'h00, "reld_0", got);
      chk("reld_0_lit", got, 8'hC0);
      do_read(8'h01, "reld_1", got);
      chk("reld_1_lit", got, 8'hB1);
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 9);
         out_ready = 1'($urandom);
         a = 8'($urandom);
         if (r < 4) do_write($urandom_range(0, 3) == 0 ? 8'hFF : a, 8'($urandom), r == 0);
         else if (r < 8) do_read((a == 8'hFF || !m_known[a]) ? 8'hFF : a, "rnd_rd", got);
         else tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 255; i++) begin
         beat(8'($urandom), 1'b0);
         if (i == 10) begin
            do_write(8'h00, ~m_mem[0], 1'b0);
            addr_bus = 8'h01;
            c_mrd    = 1'b1;
            mem_clk  = 1'b1;
            tick();
            mem_clk = 1'b0;
            probe_z("load_rd_z");
            c_mrd = 1'b0;
         end
      end
      beat(8'h55, 1'b1);
      do_read(8'h00, "full_00", got);
      do_read(8'h7F, "full_7f", got);
      do_read(8'hFE, "full_fe", got);
      do_read(8'hFF, "full_stat", got);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
